// File: rtl/regfile_sb_if.sv
// Bus between decode/issue/writeback and the scoreboarded register file.
// The master drives addresses, writeback and reserve requests; the slave returns operands and status.
interface regfile_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [DATA_W-1:0]   rd_data_a;
    logic [DATA_W-1:0]   rd_data_b;
    logic                rd_ready_a;
    logic                rd_ready_b;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                rsv_en;
    logic [ADDR_W-1:0]   rsv_addr;
    logic                rsv_ok;
    logic [NUM_REGS-1:0] pending_vec;
    logic [ADDR_W:0]     pending_cnt;

    modport master (
        output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data_a, rd_data_b, rd_ready_a, rd_ready_b, rsv_ok, pending_vec, pending_cnt
    );

    modport slave (
        input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data_a, rd_data_b, rd_ready_a, rd_ready_b, rsv_ok, pending_vec, pending_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with two bypassed combinational read ports, one write port, R0 tied to zero,
// and a per-register pending bit so issue can reserve a destination until writeback.
module regfile_sb #(
    parameter int          DATA_W   = 32,
    parameter int          NUM_REGS = 32,
    parameter int          ADDR_W   = $clog2(NUM_REGS),
    parameter logic [31:0] R1_INIT  = 32'h0000_00A5,
    parameter logic [31:0] R2_INIT  = 32'hFFFF_FF5A
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);
    localparam logic [DATA_W-1:0] R1_INIT_W = DATA_W'(R1_INIT);
    localparam logic [DATA_W-1:0] R2_INIT_W = DATA_W'(R2_INIT);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_pending;
    logic [ADDR_W:0]     r_pending_cnt;

    logic                w_wr_commit;
    logic                w_hit_a;
    logic                w_hit_b;
    logic                w_hit_rsv;
    logic                w_rsv_ok;
    logic                w_clr_hit;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [ADDR_W:0]     w_pending_cnt_nxt;

    assign w_wr_commit = bus.wr_en && (bus.wr_addr != '0);

    // A same-cycle writeback to the addressed register forwards the value it will commit.
    assign w_hit_a   = bus.wr_en && (bus.wr_addr == bus.rd_addr_a);
    assign w_hit_b   = bus.wr_en && (bus.wr_addr == bus.rd_addr_b);
    assign w_hit_rsv = bus.wr_en && (bus.wr_addr == bus.rsv_addr);

    assign bus.rd_data_a = (bus.rd_addr_a == '0) ? '0 :
                           w_hit_a               ? bus.wr_data :
                                                   r_regs[bus.rd_addr_a];
    assign bus.rd_data_b = (bus.rd_addr_b == '0) ? '0 :
                           w_hit_b               ? bus.wr_data :
                                                   r_regs[bus.rd_addr_b];

    assign bus.rd_ready_a = (bus.rd_addr_a == '0) || !r_pending[bus.rd_addr_a] || w_hit_a;
    assign bus.rd_ready_b = (bus.rd_addr_b == '0) || !r_pending[bus.rd_addr_b] || w_hit_b;

    // A pending register may be re-reserved only when its writeback lands in the same cycle.
    assign w_rsv_ok   = bus.rsv_en && (bus.rsv_addr != '0) &&
                        (!r_pending[bus.rsv_addr] || w_hit_rsv);
    assign bus.rsv_ok = w_rsv_ok;

    assign w_clr_hit = w_wr_commit && r_pending[bus.wr_addr];

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wr_commit) begin
            w_pending_nxt[bus.wr_addr] = 1'b0;
        end
        // Set after clear: a new reservation outranks the writeback of the old producer.
        if (w_rsv_ok) begin
            w_pending_nxt[bus.rsv_addr] = 1'b1;
        end
    end

    assign w_pending_cnt_nxt = r_pending_cnt + (ADDR_W+1)'(w_rsv_ok) - (ADDR_W+1)'(w_clr_hit);

    // NOTE: the array is reset because R1/R2 carry architectural reset values; this keeps it in flops rather than RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[1] <= R1_INIT_W;
            r_regs[2] <= R2_INIT_W;
        end else if (w_wr_commit) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending     <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pending     <= w_pending_nxt;
            r_pending_cnt <= w_pending_cnt_nxt;
        end
    end

    assign bus.pending_vec = r_pending;
    assign bus.pending_cnt = r_pending_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a randomized run
// compared against an array-based reference model of the register/scoreboard rules.
module tb_regfile_sb;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    logic clk;
    logic reset;

    int n_total;
    int n_pass;

    logic [DATA_W-1:0] m_regs [NUM_REGS];
    bit                m_pend [NUM_REGS];

    regfile_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
        m_regs[1] = 32'h0000_00A5;
        m_regs[2] = 32'hFFFF_FF5A;
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_ready(input logic [ADDR_W-1:0] a);
        return (a == 0) || !m_pend[a] || (bus.wr_en && bus.wr_addr == a);
    endfunction

    function automatic logic exp_rsv_ok();
        return bus.rsv_en && (bus.rsv_addr != 0) &&
               (!m_pend[bus.rsv_addr] || (bus.wr_en && bus.wr_addr == bus.rsv_addr));
    endfunction

    function automatic logic [NUM_REGS-1:0] exp_vec();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < NUM_REGS; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    // Advance the model with the inputs presented this cycle, then cross the clock edge.
    task automatic tick();
        logic ok;
        ok = exp_rsv_ok();
        if (bus.wr_en && bus.wr_addr != 0) begin
            m_regs[bus.wr_addr] = bus.wr_data;
            m_pend[bus.wr_addr] = 1'b0;
        end
        if (ok) m_pend[bus.rsv_addr] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rsv_en    = 1'b0;
        bus.rsv_addr  = '0;
    endtask

    task automatic test_reset();
        // Build up some state, then assert reset between edges.
        bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 32'hCAFE_0001;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        tick();
        idle_inputs();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
        tick();
        idle_inputs();
        bus.rd_addr_a = 5'd1;
        bus.rd_addr_b = 5'd2;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (bus.rd_data_a !== 32'h0000_00A5) $display("FAIL reset_r1: got %h want %h", bus.rd_data_a, 32'h0000_00A5);
        else n_pass++;
        n_total++;
        if (bus.rd_data_b !== 32'hFFFF_FF5A) $display("FAIL reset_r2: got %h want %h", bus.rd_data_b, 32'hFFFF_FF5A);
        else n_pass++;
        n_total++;
        if (bus.pending_vec !== '0) $display("FAIL reset_pending_vec: got %h want 0", bus.pending_vec);
        else n_pass++;
        n_total++;
        if (bus.pending_cnt !== '0) $display("FAIL reset_pending_cnt: got %0d want 0", bus.pending_cnt);
        else n_pass++;
        bus.rd_addr_a = 5'd0;
        bus.rd_addr_b = 5'd3;
        #1;
        n_total++;
        if (bus.rd_data_a !== '0) $display("FAIL reset_r0: got %h want 0", bus.rd_data_a);
        else n_pass++;
        n_total++;
        if (bus.rd_ready_b !== 1'b1) $display("FAIL reset_ready_r3: got %b want 1", bus.rd_ready_b);
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_bypass();
        idle_inputs();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'h0000_1234;
        bus.rd_addr_a = 5'd5;
        #1;
        n_total++;
        if (bus.rd_data_a !== 32'h0000_1234) $display("FAIL bypass_data: got %h want %h", bus.rd_data_a, 32'h0000_1234);
        else n_pass++;
        n_total++;
        if (bus.rd_ready_a !== 1'b1) $display("FAIL bypass_ready: got %b want 1", bus.rd_ready_a);
        else n_pass++;
        tick();
        bus.wr_en = 1'b0;
        #1;
        n_total++;
        if (bus.rd_data_a !== 32'h0000_1234) $display("FAIL array_data: got %h want %h", bus.rd_data_a, 32'h0000_1234);
        else n_pass++;
    endtask

    task automatic test_r0();
        idle_inputs();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h0000_DEAD;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
        bus.rd_addr_a = 5'd0;
        #1;
        n_total++;
        if (bus.rd_data_a !== '0) $display("FAIL r0_bypass: got %h want 0", bus.rd_data_a);
        else n_pass++;
        n_total++;
        if (bus.rsv_ok !== 1'b0) $display("FAIL r0_rsv_ok: got %b want 0", bus.rsv_ok);
        else n_pass++;
        tick();
        idle_inputs();
        #1;
        n_total++;
        if (bus.rd_data_a !== '0) $display("FAIL r0_after: got %h want 0", bus.rd_data_a);
        else n_pass++;
        n_total++;
        if (bus.pending_vec !== '0) $display("FAIL r0_pending_vec: got %h want 0", bus.pending_vec);
        else n_pass++;
    endtask

    task automatic test_reserve();
        idle_inputs();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7; bus.rd_addr_b = 5'd7;
        #1;
        n_total++;
        if (bus.rsv_ok !== 1'b1) $display("FAIL rsv7_ok: got %b want 1", bus.rsv_ok);
        else n_pass++;
        n_total++;
        if (bus.rd_ready_b !== 1'b1) $display("FAIL rsv7_ready_same_cycle: got %b want 1", bus.rd_ready_b);
        else n_pass++;
        tick();
        n_total++;
        if (bus.rd_ready_b !== 1'b0) $display("FAIL rsv7_ready_next: got %b want 0", bus.rd_ready_b);
        else n_pass++;
        n_total++;
        if (bus.pending_cnt !== 6'd1) $display("FAIL rsv7_cnt: got %0d want 1", bus.pending_cnt);
        else n_pass++;
        n_total++;
        if (bus.rsv_ok !== 1'b0) $display("FAIL rsv7_waw_refused: got %b want 0", bus.rsv_ok);
        else n_pass++;
        tick();
        bus.rsv_en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h0000_0055;
        #1;
        n_total++;
        if (bus.rd_ready_b !== 1'b1 || bus.rd_data_b !== 32'h0000_0055)
            $display("FAIL wb7_bypass: got ready=%b data=%h want ready=1 data=%h", bus.rd_ready_b, bus.rd_data_b, 32'h0000_0055);
        else n_pass++;
        tick();
        bus.wr_en = 1'b0;
        #1;
        n_total++;
        if (bus.pending_vec[7] !== 1'b0 || bus.pending_cnt !== 6'd0)
            $display("FAIL wb7_cleared: got pend=%b cnt=%0d want pend=0 cnt=0", bus.pending_vec[7], bus.pending_cnt);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        idle_inputs();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h9999_0009;
        #1;
        n_total++;
        if (bus.rsv_ok !== 1'b1) $display("FAIL same9_rsv_ok: got %b want 1", bus.rsv_ok);
        else n_pass++;
        tick();
        idle_inputs();
        bus.rd_addr_a = 5'd9;
        #1;
        n_total++;
        if (bus.rd_data_a !== 32'h9999_0009) $display("FAIL same9_data: got %h want %h", bus.rd_data_a, 32'h9999_0009);
        else n_pass++;
        n_total++;
        if (bus.pending_vec[9] !== 1'b1 || bus.pending_cnt !== 6'd1)
            $display("FAIL same9_pending: got pend=%b cnt=%0d want pend=1 cnt=1", bus.pending_vec[9], bus.pending_cnt);
        else n_pass++;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h0;
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] ea;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // Bias toward a few low registers so collisions and WAW refusals are frequent.
            ea = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            bus.rd_addr_a = ea;
            bus.rd_addr_b = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            bus.wr_en     = ($urandom_range(0, 2) == 0);
            bus.wr_addr   = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            bus.wr_data   = $urandom;
            bus.rsv_en    = ($urandom_range(0, 1) == 0);
            bus.rsv_addr  = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
            #1;
            n_total++;
            if (bus.rd_data_a !== exp_data(bus.rd_addr_a))
                $display("FAIL rand_data_a @%0d: got %h want %h", cyc, bus.rd_data_a, exp_data(bus.rd_addr_a));
            else n_pass++;
            n_total++;
            if (bus.rd_data_b !== exp_data(bus.rd_addr_b))
                $display("FAIL rand_data_b @%0d: got %h want %h", cyc, bus.rd_data_b, exp_data(bus.rd_addr_b));
            else n_pass++;
            n_total++;
            if (bus.rd_ready_a !== exp_ready(bus.rd_addr_a))
                $display("FAIL rand_ready_a @%0d: got %b want %b", cyc, bus.rd_ready_a, exp_ready(bus.rd_addr_a));
            else n_pass++;
            n_total++;
            if (bus.rd_ready_b !== exp_ready(bus.rd_addr_b))
                $display("FAIL rand_ready_b @%0d: got %b want %b", cyc, bus.rd_ready_b, exp_ready(bus.rd_addr_b));
            else n_pass++;
            n_total++;
            if (bus.rsv_ok !== exp_rsv_ok())
                $display("FAIL rand_rsv_ok @%0d: got %b want %b", cyc, bus.rsv_ok, exp_rsv_ok());
            else n_pass++;
            n_total++;
            if (bus.pending_vec !== exp_vec())
                $display("FAIL rand_pending_vec @%0d: got %h want %h", cyc, bus.pending_vec, exp_vec());
            else n_pass++;
            n_total++;
            if (int'(bus.pending_cnt) != exp_cnt())
                $display("FAIL rand_pending_cnt @%0d: got %0d want %0d", cyc, bus.pending_cnt, exp_cnt());
            else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b1;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_bypass();
        test_r0();
        test_reserve();
        test_same_cycle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
